// File: rtl/clock_fault_classifier.sv
// clock_fault_classifier
// Classifies each ref_clk measurement window's clk edge count as GOOD, SLOW,
// FAST or HALTED. A debounce FSM turns these classes into a qualified fault
// alarm with a cause code and a sticky "fault occurred" flag. If no window
// arrives for TIMEOUT cycles, a synthetic HALTED window is generated.
// Optional min/max count tracking is enabled with `define CLK_MON_MINMAX_EN.
//
// Input strobe: cnt_valid is a one-cycle pulse with no back-pressure. There
// is no ready signal. cnt_value is sampled only in a cycle where cnt_valid=1.
module clock_fault_classifier #(
  parameter int CNT_W   = 16,
  parameter int EXP_LO  = 8,
  parameter int EXP_HI  = 12,
  parameter int FAULT_N = 3,
  parameter int CLEAR_N = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_value,
  input  logic             cnt_valid,
  input  logic             sticky_clr,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic             fault_sticky,
  output logic             win_event,
  output logic [2:0]       fsm_state
`ifdef CLK_MON_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_cnt,
  output logic [CNT_W-1:0] max_cnt
`endif
);

  localparam int MAX_N = (FAULT_N > CLEAR_N) ? FAULT_N : CLEAR_N;
  localparam int CW    = $clog2(MAX_N) + 1;
  localparam int TW    = $clog2(TIMEOUT);

  localparam logic [CW-1:0] FAULT_TH = CW'(FAULT_N);
  localparam logic [CW-1:0] CLEAR_TH = CW'(CLEAR_N);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OK      = 3'd1,
    S_SUSPECT = 3'd2,
    S_FAULT   = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  // Class encoding doubles as the fault cause code.
  typedef enum logic [1:0] {
    C_GOOD = 2'b00,
    C_SLOW = 2'b01,
    C_FAST = 2'b10,
    C_HALT = 2'b11
  } cls_t;

  state_t          state, state_n;
  logic [CW-1:0]   bad_cnt, bad_n, bad_inc;
  logic [CW-1:0]   good_cnt, good_n, good_inc;
  logic [TW-1:0]   timer;
  logic [1:0]      code_n;
  logic            sticky_n;
  logic            expire, ev, is_bad;
  cls_t            cls_raw, cls;

  // Classify the incoming count; a timeout expiry is reported as HALTED.
  always_comb begin
    cls_raw = C_GOOD;
    if (cnt_value == '0)                  cls_raw = C_HALT;
    else if (cnt_value < CNT_W'(EXP_LO))  cls_raw = C_SLOW;
    else if (cnt_value > CNT_W'(EXP_HI))  cls_raw = C_FAST;
    expire   = !cnt_valid && (timer == TMR_LAST);
    ev       = cnt_valid || expire;
    cls      = cnt_valid ? cls_raw : C_HALT;
    is_bad   = (cls != C_GOOD);
    bad_inc  = (bad_cnt  < FAULT_TH) ? bad_cnt  + CW'(1) : bad_cnt;
    good_inc = (good_cnt < CLEAR_TH) ? good_cnt + CW'(1) : good_cnt;
  end

  // Timeout timer: counts idle cycles, restarts on a real or synthetic window.
  always_ff @(posedge ref_clk) begin
    if (!rst_n)             timer <= '0;
    else if (ev)            timer <= '0;
    else                    timer <= timer + TW'(1);
  end

  // Debounce FSM next-state, counters and cause code.
  always_comb begin
    state_n = state;
    bad_n   = bad_cnt;
    good_n  = good_cnt;
    code_n  = fault_code;
    case (state)
      S_IDLE, S_OK: begin
        if (ev) begin
          if (!is_bad) begin
            state_n = S_OK;
            bad_n   = '0;
          end else if (FAULT_N == 1) begin
            state_n = S_FAULT;
            code_n  = cls;
          end else begin
            state_n = S_SUSPECT;
            bad_n   = CW'(1);
          end
        end
      end
      S_SUSPECT: begin
        if (ev) begin
          if (!is_bad) begin
            state_n = S_OK;
            bad_n   = '0;
          end else if (bad_inc >= FAULT_TH) begin
            state_n = S_FAULT;
            code_n  = cls;
            bad_n   = '0;
          end else begin
            bad_n   = bad_inc;
          end
        end
      end
      S_FAULT: begin
        if (ev) begin
          if (is_bad) begin
            code_n  = cls;
          end else if (CLEAR_N == 1) begin
            state_n = S_OK;
            code_n  = 2'b00;
            good_n  = '0;
          end else begin
            state_n = S_RECOVER;
            good_n  = CW'(1);
          end
        end
      end
      S_RECOVER: begin
        if (ev) begin
          if (is_bad) begin
            state_n = S_FAULT;
            good_n  = '0;
            code_n  = cls;
          end else if (good_inc >= CLEAR_TH) begin
            state_n = S_OK;
            good_n  = '0;
            code_n  = 2'b00;
          end else begin
            good_n  = good_inc;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        bad_n   = '0;
        good_n  = '0;
        code_n  = 2'b00;
      end
    endcase
    // Entering FAULT sets the sticky flag and beats a simultaneous clear.
    if (state_n == S_FAULT && state != S_FAULT) sticky_n = 1'b1;
    else if (sticky_clr)                        sticky_n = 1'b0;
    else                                        sticky_n = fault_sticky;
  end

  // State, counters and registered outputs.
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bad_cnt      <= '0;
      good_cnt     <= '0;
      fault        <= 1'b0;
      fault_code   <= 2'b00;
      fault_sticky <= 1'b0;
      win_event    <= 1'b0;
    end else begin
      state        <= state_n;
      bad_cnt      <= bad_n;
      good_cnt     <= good_n;
      fault        <= (state_n == S_FAULT) || (state_n == S_RECOVER);
      fault_code   <= code_n;
      fault_sticky <= sticky_n;
      win_event    <= ev;
    end
  end

  assign fsm_state = state;

`ifdef CLK_MON_MINMAX_EN
  // Min/max over real windows only; sticky_clr restarts tracking.
  always_ff @(posedge ref_clk) begin
    if (!rst_n || sticky_clr) begin
      min_cnt <= '1;
      max_cnt <= '0;
    end else if (cnt_valid) begin
      if (cnt_value < min_cnt) min_cnt <= cnt_value;
      if (cnt_value > max_cnt) max_cnt <= cnt_value;
    end
  end
`endif

endmodule

// File: doc/clock_fault_classifier.md
Name: clock_fault_classifier

Overview:
- Consumes per-window edge counts from the clock monitor counter, which counts `clk` edges per `ref_clk` measurement window.
- Classifies each window as GOOD, SLOW, FAST or HALTED.
- Debounces the classifications through an FSM into a qualified fault alarm with a cause code and a sticky flag.
- Runs entirely in the `ref_clk` domain and feeds the system fault/interrupt logic.

Parameters:
- CNT_W, 16: width of the incoming window count.
- EXP_LO, 8: lowest count accepted as GOOD (inclusive).
- EXP_HI, 12: highest count accepted as GOOD (inclusive). EXP_LO <= EXP_HI and EXP_LO >= 1.
- FAULT_N, 3: consecutive bad windows needed to assert the fault (>= 1).
- CLEAR_N, 4: consecutive GOOD windows needed to clear the fault (>= 1).
- TIMEOUT, 64: `ref_clk` cycles without `cnt_valid` before a synthetic HALTED window is generated (>= 2).

Ports:
- ref_clk, in, 1: sole clock.
- rst_n, in, 1: synchronous, active-low reset.
- cnt_value, in, CNT_W: edge count of the completed window.
- cnt_valid, in, 1: one-cycle strobe; cnt_value is valid in that cycle.
- sticky_clr, in, 1: clears the sticky flag.
- fault, out, 1: qualified fault alarm.
- fault_code, out, 2: cause of the fault. 00 none, 01 slow, 10 fast, 11 halted.
- fault_sticky, out, 1: latched "a fault occurred".
- win_event, out, 1: one-cycle pulse per classified window, real or synthetic.
- fsm_state, out, 3: current state encoding, for debug.

Behaviour:
- Reset: when rst_n=0 at a ref_clk edge, all of the following are set to 0 or IDLE: fault, fault_code, fault_sticky, win_event, both debounce counters, the timeout timer and the FSM. All outputs are registered.
- Classification (combinational, on cnt_valid):
  - cnt_value==0 -> HALTED
  - cnt_value<EXP_LO -> SLOW
  - cnt_value>EXP_HI -> FAST
  - otherwise GOOD
  - Comparisons are unsigned at CNT_W bits.
- Timeout timer:
  - Increments every cycle without cnt_valid.
  - On reaching TIMEOUT-1 it produces a synthetic HALTED event and restarts at 0.
  - cnt_valid resets the timer to 0.
  - If cnt_valid and expiry coincide, cnt_valid wins and no synthetic event is produced.
- Event: one classification per cnt_valid or timeout expiry. The FSM and outputs update on the same ref_clk edge, i.e. one cycle after the cnt_valid cycle. win_event pulses in that cycle.
- FSM (transitions occur only on events; BAD = SLOW, FAST or HALTED):
  - IDLE: GOOD -> OK. BAD -> SUSPECT with bad_cnt=1, or straight to FAULT if FAULT_N==1.
  - OK: GOOD stays. BAD -> SUSPECT with bad_cnt=1 (or FAULT if FAULT_N==1).
  - SUSPECT: BAD increments bad_cnt; when bad_cnt reaches FAULT_N -> FAULT. GOOD -> OK and bad_cnt=0. Mixed bad classes still count as consecutive.
  - FAULT: BAD stays and updates fault_code to the latest class. GOOD -> RECOVER with good_cnt=1, or straight to OK if CLEAR_N==1.
  - RECOVER: GOOD increments good_cnt; when it reaches CLEAR_N -> OK. BAD -> FAULT, good_cnt=0, fault_code updated.
- Outputs by state:
  - fault=1 exactly in FAULT and RECOVER.
  - fault_code holds the last BAD class while fault=1, and is 00 otherwise.
- fault_sticky:
  - Set on entry to FAULT.
  - Cleared by sticky_clr.
  - Set wins over sticky_clr in the same cycle.
- Counters:
  - Sized as clog2(max(FAULT_N,CLEAR_N))+1.
  - Never wrap; they stop at threshold.
- Reset mid-window: any partial debounce count is discarded. The first event after reset is treated from IDLE.

Optional Feature:
- Macro: CLK_MON_MINMAX_EN.
- When defined:
  - Adds outputs min_cnt (out, CNT_W) and max_cnt (out, CNT_W).
  - They track the minimum and maximum cnt_value over real cnt_valid windows only; synthetic timeout events are excluded.
  - Reset and sticky_clr set min_cnt to all ones and max_cnt to 0.
  - Update is registered on the cycle after cnt_valid.
- When undefined: these ports and registers are absent. All other behaviour is identical.

Test Plan:
1. Reset, then cnt_value=10 valid every 20 cycles for 5 windows -> fault=0, fault_code=00, FSM OK, win_event pulses 5 times.
2. From OK, windows 5,5,5 -> fault rises one cycle after the third strobe, fault_code=01, fault_sticky=1. Windows 5,10,5 instead -> fault stays 0.
3. Stop cnt_valid for 200 cycles -> synthetic events at 64-cycle intervals; fault=1 with fault_code=11 after the third timeout (cycle 192). A cnt_valid landing on the expiry cycle suppresses the synthetic event.
4. In FAULT, windows 10,10,10,15,10,10,10,10 -> RECOVER, back to FAULT with code 10 at the 15, then fault clears one cycle after the fourth consecutive GOOD. fault_sticky stays 1 until sticky_clr; sticky_clr on the FAULT-entry cycle leaves fault_sticky=1.
5. Assert rst_n=0 while in SUSPECT with bad_cnt=2, then apply one bad window -> SUSPECT with bad_cnt=1, fault=0.
6. With CLK_MON_MINMAX_EN, windows 10,7,14 -> min_cnt=7, max_cnt=14. After sticky_clr -> min_cnt=FFFF, max_cnt=0.
